// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to a variable-latency memory and buffers
// tagged responses in an in-order prefetch FIFO; a redirect flushes queued and in-flight work.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [CW:0] occupancy;
    logic        gnt_fire;
    logic        rv_fire;
    logic        pop;
    logic        push;
    logic [31:0] redirect_tgt;

    // Requests are throttled on registered state only, so the FIFO can never overflow.
    assign occupancy    = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req     = !rst && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_addr    = fpc_q & WORD_MASK;
    assign redirect_tgt = redirect_pc & WORD_MASK;

    assign gnt_fire    = imem_req && imem_gnt;
    assign rv_fire     = imem_rvalid && (outst_q != '0);
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    // NOTE: the storage array is never read while empty, so gating the outputs gives
    // defined reset values without paying for a reset on every entry.
    assign instr_out = instr_valid ? instr_mem[rd_ptr_q] : '0;
    assign instr_pc  = instr_valid ? pc_mem[rd_ptr_q]    : '0;

    always_comb begin
        fpc_d     = fpc_q;
        rpc_d     = rpc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        push      = 1'b0;

        if (redirect_valid) begin
            // Everything still in flight belongs to the old stream; the word arriving
            // now is dropped here, the rest through the discard counter.
            fpc_d     = redirect_tgt;
            rpc_d     = redirect_tgt;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            outst_d   = outst_q - CW'(rv_fire);
            discard_d = outst_q - CW'(rv_fire);
        end else begin
            if (gnt_fire) begin
                fpc_d = fpc_q + 32'd4;
            end
            outst_d = outst_q + CW'(gnt_fire) - CW'(rv_fire);
            if (rv_fire) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    push  = 1'b1;
                    rpc_d = rpc_q + 32'd4;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q     <= RESET_PC & WORD_MASK;
            rpc_q     <= RESET_PC & WORD_MASK;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            fpc_q     <= fpc_d;
            rpc_q     <= rpc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= rpc_q;
        end
    end

    // A response with nothing outstanding breaks the memory protocol and is ignored.
    assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && (outst_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable latency,
// a reset/throughput/backpressure vector table, and hand sequences for stall and redirect cases.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        gnt;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t pend[$];
    vec_t  vecs[16];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_pops = 0;
    int          n_grants = 0;
    logic        gnt_en = 1'b0;
    logic        ready_en = 1'b0;
    logic        redir_en = 1'b0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] exp_next = '0;
    logic        last_rv, last_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive this cycle's inputs (called just after a falling edge) and let outputs settle.
    task automatic cycle_drive();
        pend_t p;
        imem_gnt       = gnt_en;
        instr_ready    = ready_en;
        redirect_valid = redir_en;
        redirect_pc    = redir_tgt;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(p.addr);
        end
        #1;
    endtask

    // Record handshakes seen this cycle, check popped words, advance to the next falling edge.
    task automatic cycle_end();
        last_rv  = imem_rvalid;
        last_pop = instr_valid && instr_ready;
        if (imem_req && imem_gnt) begin
            pend.push_back('{imem_addr, cyc + lat});
            n_grants++;
        end
        if (last_pop) begin
            check("pop_pc", instr_pc, exp_next);
            check("pop_data", instr_out, mem_word(instr_pc));
            exp_next = exp_next + 32'd4;
            n_pops++;
        end
        if (redirect_valid) exp_next = redirect_pc & 32'hFFFF_FFFC;
        redir_en = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle();
        cycle_drive();
        cycle_end();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        redir_en       = 1'b0;
        pend.delete();
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_outst", 32'(dut.outst_q), 32'd0);
        check("rst_discard", 32'(dut.discard_q), 32'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        exp_next = RESET_PC;
        n_pops   = 0;
        n_grants = 0;
    endtask

    initial begin
        int pops_before;
        bit hit;

        // Reset release, 1-cycle memory: throughput, then ready low for 5 cycles, then drain.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

        do_reset();
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            gnt_en   = vecs[i].gnt;
            ready_en = vecs[i].ready;
            cycle_drive();
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("v%0d_pc", i), instr_pc, vecs[i].exp_pc);
            cycle_end();
        end

        // Backpressure from reset: exactly DEPTH grants, then requests stop; drain in order.
        do_reset();
        lat = 1; gnt_en = 1'b1; ready_en = 1'b0;
        repeat (10) cycle();
        check("bp_grants", 32'(n_grants), 32'(DEPTH));
        cycle_drive();
        check("bp_req_off", 32'(imem_req), 32'd0);
        check("bp_count", 32'(dut.count_q), 32'(DEPTH));
        cycle_end();
        ready_en = 1'b1;
        repeat (6) cycle();
        check("bp_drain_pops", 32'(n_pops), 32'd6);

        // Grant stall: address holds while req is high and gnt is low.
        do_reset();
        lat = 1; gnt_en = 1'b0; ready_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle_drive();
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", imem_addr, 32'h0);
            cycle_end();
        end
        gnt_en = 1'b1;
        cycle_drive();
        check("stall_gnt_addr", imem_addr, 32'h0);
        cycle_end();
        cycle_drive();
        check("stall_next_addr", imem_addr, 32'h4);
        cycle_end();

        // 3-cycle memory, redirect with two requests in flight.
        do_reset();
        lat = 3; gnt_en = 1'b1; ready_en = 1'b1;
        cycle();
        cycle();
        redir_en = 1'b1; redir_tgt = 32'h0000_0100;
        cycle_drive();
        check("redir_req_low", 32'(imem_req), 32'd0);
        cycle_end();
        check("redir_discard", 32'(dut.discard_q), 32'd2);
        cycle_drive();
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        cycle_end();
        repeat (12) cycle();
        check("redir_pops_seen", 32'(n_pops >= 3), 32'd1);

        // Redirect landing together with a pop and an rvalid; target wraps through zero.
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            cycle_drive();
            if (imem_rvalid && instr_valid && instr_ready) begin
                hit            = 1'b1;
                redir_en       = 1'b1;
                redir_tgt      = 32'hFFFF_FFFC;
                redirect_valid = 1'b1;
                redirect_pc    = redir_tgt;
                #1;
            end
            cycle_end();
        end
        check("combo_found", 32'(hit), 32'd1);
        check("combo_rv", 32'(last_rv), 32'd1);
        check("combo_pop", 32'(last_pop), 32'd1);
        check("combo_discard", 32'(dut.discard_q), 32'(pend.size()));
        pops_before = n_pops;
        repeat (12) cycle();
        check("wrap_pops_seen", 32'(n_pops - pops_before >= 2), 32'd1);
        check("wrap_next_pc_advanced", 32'(exp_next < 32'h100), 32'd1);

        // Reset mid-stream clears state immediately; first cycle after release fetches RESET_PC.
        do_reset();
        gnt_en = 1'b1; ready_en = 1'b1; lat = 1;
        cycle_drive();
        check("rerst_req", 32'(imem_req), 32'd1);
        check("rerst_addr", imem_addr, RESET_PC);
        cycle_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
